// File: rtl/mem_req_arbiter.sv
// Shares the single SPI flash read engine between the instruction-fetch (if) and load/store (ls) ports.
// Optional feature: define ARB_ROUND_ROBIN_EN to break request ties round-robin instead of ls-first.
module mem_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [23:0] ls_addr,
  output logic        ls_valid,
  output logic [31:0] ls_data,
  output logic        ls_err,
  output logic        mem_start,
  output logic [23:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic        GRANT_IF = 1'b0;
  localparam logic        GRANT_LS = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state_q, state_d;
  logic        grant_q;
  logic [15:0] cnt_q;
  logic [23:0] addr_q;
  logic [31:0] if_data_q, ls_data_q;
  logic        if_err_q, ls_err_q;
  logic        any_req, pick_ls;
  logic        grant_load, finish, finish_err;

  assign any_req = if_req || ls_req;

  // grant_q only changes on a grant, so it doubles as the last-grant register.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_ls = ls_req && (!if_req || (grant_q == GRANT_IF));
`else
  assign pick_ls = ls_req;
`endif

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_load = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // A completion in the same cycle as the watchdog expiry is still a good read.
        if (mem_done) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: begin
        if (!mem_done) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= GRANT_IF;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else if (grant_load) begin
      grant_q <= pick_ls;
      cnt_q   <= '0;
      addr_q  <= pick_ls ? ls_addr : if_addr;
    end else if ((state_q == S_BUSY) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Per-port result registers hold until that port's next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_data_q <= '0;
      if_err_q  <= 1'b0;
      ls_data_q <= '0;
      ls_err_q  <= 1'b0;
    end else if (finish) begin
      if (grant_q == GRANT_LS) begin
        ls_data_q <= finish_err ? 32'd0 : mem_data;
        ls_err_q  <= finish_err;
      end else begin
        if_data_q <= finish_err ? 32'd0 : mem_data;
        if_err_q  <= finish_err;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_start = (state_q == S_BUSY);
  assign mem_addr  = addr_q;
  assign if_valid  = (state_q == S_DONE) && (grant_q == GRANT_IF);
  assign ls_valid  = (state_q == S_DONE) && (grant_q == GRANT_LS);
  assign if_data   = if_data_q;
  assign if_err    = if_err_q;
  assign ls_data   = ls_data_q;
  assign ls_err    = ls_err_q;

endmodule
